// File: rtl/rec_mul8_seq.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 core, nibble products accumulated over up to four cycles.
// Define APPROX_LL_EN to use the approximate OR-compressor cell for the low-nibble (LL) step.
module rec_mul8_seq #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Y,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic [3:0]  mask_q, mask_d, mask_new;
  logic [15:0] acc_q, acc_d, addend;
  logic [7:0]  a_q, b_q, prod;
  logic [3:0]  na, nb;
  logic [1:0]  step;

  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    return {4'd0, x} * {4'd0, y};
  endfunction

`ifdef APPROX_LL_EN
  function automatic logic [7:0] ll_core(input logic [3:0] x, input logic [3:0] y);
    logic [3:0][3:0] p;
    logic [7:0]      r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        p[i][j] = x[i] & y[j];
    r[0] = p[0][0];
    r[1] = p[1][0] | p[0][1];
    r[2] = p[2][0] | p[1][1] | p[0][2];
    r[3] = p[3][0] | p[2][1] | p[1][2] | p[0][3];
    r[4] = p[3][1] | p[2][2] | p[1][3];
    r[5] = p[3][2] | p[2][3];
    r[6] = p[3][3] & ~p[2][2];
    r[7] = p[3][3] & p[2][2];
    return r;
  endfunction
`else
  function automatic logic [7:0] ll_core(input logic [3:0] x, input logic [3:0] y);
    return mul4(x, y);
  endfunction
`endif

  // Mask bit order: [0]=LL, [1]=HL, [2]=LH, [3]=HH; a zero nibble on either side forces a zero sub-product.
  always_comb begin
    mask_new = 4'hF;
    if (SKIP_ZERO) begin
      mask_new[0] = (a[3:0] != 4'd0) && (b[3:0] != 4'd0);
      mask_new[1] = (a[7:4] != 4'd0) && (b[3:0] != 4'd0);
      mask_new[2] = (a[3:0] != 4'd0) && (b[7:4] != 4'd0);
      mask_new[3] = (a[7:4] != 4'd0) && (b[7:4] != 4'd0);
    end
  end

  always_comb begin
    step = 2'd3;
    if (mask_q[0])      step = 2'd0;
    else if (mask_q[1]) step = 2'd1;
    else if (mask_q[2]) step = 2'd2;
    na     = step[0] ? a_q[7:4] : a_q[3:0];
    nb     = step[1] ? b_q[7:4] : b_q[3:0];
    prod   = (step == 2'd0) ? ll_core(na, nb) : mul4(na, nb);
    case (step)
      2'd0:    addend = {8'd0, prod};
      2'd3:    addend = {prod, 8'd0};
      default: addend = {4'd0, prod, 4'd0};
    endcase
    mask_d = mask_q & ~(4'b0001 << step);
    acc_d  = acc_q + addend;
  end

  // Operands are pure data, captured only on the accept edge.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= 4'd0;
      acc_q   <= 16'd0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          acc_q   <= 16'd0;
          mask_q  <= mask_new;
          state_q <= (mask_new == 4'd0) ? DONE : CALC;
        end
        CALC: begin
          acc_q  <= acc_d;
          mask_q <= mask_d;
          if (mask_d == 4'd0) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign Y         = acc_q;

endmodule
